// File: rtl/sdp_mrdma_eg_lanes.sv
// sdp_mrdma_eg_lanes: splits read responses from the selected source into
// per-lane FIFOs and reassembles masked output beats under command control.
module sdp_mrdma_eg_lanes #(
   parameter  int unsigned LANES   = 4,
   parameter  int unsigned LANE_W  = 128,
   parameter  int unsigned DEPTH   = 8,
   parameter  int unsigned NUM_SRC = 2,
   parameter  int unsigned CNT_W   = 13,
   localparam int unsigned SEL_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
   localparam int unsigned CMD_W   = CNT_W + LANES + 1,
   localparam int unsigned BEAT_W  = LANES + LANES * LANE_W
) (
   input  logic                      nvdla_core_clk,
   input  logic                      nvdla_core_rst,
   input  logic                      cmd_pvld,
   output logic                      cmd_prdy,
   input  logic [CMD_W-1:0]          cmd_pd,
   input  logic [NUM_SRC-1:0]        rsp_valid,
   output logic [NUM_SRC-1:0]        rsp_ready,
   input  logic [NUM_SRC*BEAT_W-1:0] rsp_pd,
   output logic [NUM_SRC-1:0]        rd_cdt_lat_fifo_pop,
   input  logic [SEL_W-1:0]          reg2dp_src_sel,
   input  logic                      op_load,
   output logic                      dout_valid,
   input  logic                      dout_ready,
   output logic [BEAT_W-1:0]         dout_pd,
   output logic                      eg_done,
   output logic [31:0]               dp2reg_beat_num
);

   localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned OCC_W  = PTR_W + 1;
   localparam int unsigned DATA_W = LANES * LANE_W;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Registered state
   state_t             state_q, state_d;
   logic [LANES-1:0]   cmd_mask_q, cmd_mask_d;
   logic [CNT_W-1:0]   cmd_cnt_q, cmd_cnt_d;
   logic               cmd_last_q, cmd_last_d;
   logic [CNT_W-1:0]   beat_q, beat_d;
   logic               eg_done_q, eg_done_d;
   logic [NUM_SRC-1:0] cdt_pop_q, cdt_pop_d;
   logic [31:0]        beat_num_q, beat_num_d;
   logic [PTR_W-1:0]   wr_ptr_q [LANES];
   logic [PTR_W-1:0]   wr_ptr_d [LANES];
   logic [PTR_W-1:0]   rd_ptr_q [LANES];
   logic [PTR_W-1:0]   rd_ptr_d [LANES];
   logic [OCC_W-1:0]   occ_q    [LANES];
   logic [OCC_W-1:0]   occ_d    [LANES];
   logic [LANE_W-1:0]  mem_q    [LANES][DEPTH];

   // Combinational helpers
   logic [BEAT_W-1:0]  sel_pd_c;
   logic               sel_ok_c;
   logic [LANES-1:0]   sel_mask_c;
   logic [DATA_W-1:0]  sel_data_c;
   logic               lane_ok_c;
   logic [NUM_SRC-1:0] rsp_acc_c;
   logic [LANES-1:0]   full_c;
   logic [LANES-1:0]   empty_c;
   logic [LANES-1:0]   push_c;
   logic [LANES-1:0]   pop_c;
   logic               lanes_rdy_c;
   logic               dout_acc_c;
   logic [DATA_W-1:0]  dout_data_c;

   // Pick the response slice addressed by the source-select register
   always_comb begin
      sel_pd_c = '0;
      sel_ok_c = 1'b0;
      for (int unsigned s = 0; s < NUM_SRC; s++) begin
         if (reg2dp_src_sel == SEL_W'(s)) begin
            sel_pd_c = rsp_pd[s*BEAT_W +: BEAT_W];
            sel_ok_c = 1'b1;
         end
      end
   end

   assign sel_mask_c = sel_pd_c[BEAT_W-1 -: LANES];
   assign sel_data_c = sel_pd_c[DATA_W-1:0];

   // Per-lane full/empty from the registered occupancy only
   always_comb begin
      full_c  = '0;
      empty_c = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         full_c[i]  = (occ_q[i] == OCC_W'(DEPTH));
         empty_c[i] = (occ_q[i] == '0);
      end
   end

   // Ready only for the selected source, and only if its masked lanes have room
   always_comb begin
      lane_ok_c = &(~sel_mask_c | ~full_c);
      rsp_ready = '0;
      for (int unsigned s = 0; s < NUM_SRC; s++) begin
         if (sel_ok_c && (reg2dp_src_sel == SEL_W'(s))) begin
            rsp_ready[s] = lane_ok_c;
         end
      end
   end

   assign rsp_acc_c = rsp_valid & rsp_ready;
   assign push_c    = (|rsp_acc_c) ? sel_mask_c : '0;
   assign cdt_pop_d = rsp_acc_c;

   // Lane FIFO pointer and occupancy update
   always_comb begin
      for (int unsigned i = 0; i < LANES; i++) begin
         wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(push_c[i]);
         rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(pop_c[i]);
         occ_d[i]    = occ_q[i] + OCC_W'(push_c[i]) - OCC_W'(pop_c[i]);
      end
   end

   // Lane FIFO storage; contents are don't-care until written
   always_ff @(posedge nvdla_core_clk) begin
      for (int unsigned i = 0; i < LANES; i++) begin
         if (push_c[i]) begin
            mem_q[i][wr_ptr_q[i]] <= sel_data_c[i*LANE_W +: LANE_W];
         end
      end
   end

   // Output beat: heads of masked lanes, zeros elsewhere
   always_comb begin
      dout_data_c = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         if (cmd_mask_q[i]) begin
            dout_data_c[i*LANE_W +: LANE_W] = mem_q[i][rd_ptr_q[i]];
         end
      end
   end

   assign lanes_rdy_c = &(~cmd_mask_q | ~empty_c);
   assign dout_pd     = (state_q == ST_RUN) ? {cmd_mask_q, dout_data_c} : '0;
   assign dout_acc_c  = dout_valid & dout_ready;

   // Egress FSM: command latch, beat emission and completion
   always_comb begin
      state_d    = state_q;
      cmd_mask_d = cmd_mask_q;
      cmd_cnt_d  = cmd_cnt_q;
      cmd_last_d = cmd_last_q;
      beat_d     = beat_q;
      eg_done_d  = 1'b0;
      cmd_prdy   = 1'b0;
      dout_valid = 1'b0;
      pop_c      = '0;
      unique case (state_q)
         ST_IDLE: begin
            cmd_prdy = 1'b1;
            if (cmd_pvld) begin
               cmd_cnt_d  = cmd_pd[CNT_W-1:0];
               cmd_mask_d = cmd_pd[CNT_W +: LANES];
               cmd_last_d = cmd_pd[CNT_W+LANES];
               beat_d     = '0;
               if (cmd_pd[CNT_W +: LANES] != '0) begin
                  state_d = ST_RUN;
               end else begin
                  eg_done_d = cmd_pd[CNT_W+LANES];
               end
            end
         end
         ST_RUN: begin
            dout_valid = lanes_rdy_c;
            if (lanes_rdy_c && dout_ready) begin
               pop_c  = cmd_mask_q;
               beat_d = beat_q + CNT_W'(1);
               if (beat_q == cmd_cnt_q) begin
                  state_d   = ST_IDLE;
                  eg_done_d = cmd_last_q;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Accepted-beat counter: saturating, cleared by op_load
   always_comb begin
      beat_num_d = beat_num_q;
      if (dout_acc_c && (beat_num_q != 32'hFFFF_FFFF)) begin
         beat_num_d = beat_num_q + 32'd1;
      end
      if (op_load) begin
         beat_num_d = dout_acc_c ? 32'd1 : 32'd0;
      end
   end

   // State registers
   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         state_q    <= ST_IDLE;
         cmd_mask_q <= '0;
         cmd_cnt_q  <= '0;
         cmd_last_q <= 1'b0;
         beat_q     <= '0;
         eg_done_q  <= 1'b0;
         cdt_pop_q  <= '0;
         beat_num_q <= '0;
         for (int unsigned i = 0; i < LANES; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            occ_q[i]    <= '0;
         end
      end else begin
         state_q    <= state_d;
         cmd_mask_q <= cmd_mask_d;
         cmd_cnt_q  <= cmd_cnt_d;
         cmd_last_q <= cmd_last_d;
         beat_q     <= beat_d;
         eg_done_q  <= eg_done_d;
         cdt_pop_q  <= cdt_pop_d;
         beat_num_q <= beat_num_d;
         for (int unsigned i = 0; i < LANES; i++) begin
            wr_ptr_q[i] <= wr_ptr_d[i];
            rd_ptr_q[i] <= rd_ptr_d[i];
            occ_q[i]    <= occ_d[i];
         end
      end
   end

   assign eg_done             = eg_done_q;
   assign rd_cdt_lat_fifo_pop = cdt_pop_q;
   assign dp2reg_beat_num     = beat_num_q;

endmodule

// File: tb/tb_sdp_mrdma_eg_lanes.sv
// tb_sdp_mrdma_eg_lanes: directed plus random stimulus checked against a
// queue-based behavioural model of the egress stage.
module tb_sdp_mrdma_eg_lanes;

   localparam int unsigned LANES   = 4;
   localparam int unsigned LANE_W  = 128;
   localparam int unsigned DEPTH   = 8;
   localparam int unsigned NUM_SRC = 3;
   localparam int unsigned CNT_W   = 13;
   localparam int unsigned SEL_W   = 2;
   localparam int unsigned CMD_W   = CNT_W + LANES + 1;
   localparam int unsigned BEAT_W  = LANES + LANES * LANE_W;
   localparam int unsigned DATA_W  = LANES * LANE_W;

   typedef logic [LANE_W-1:0] lane_t;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      cmd_pvld;
   logic                      cmd_prdy;
   logic [CMD_W-1:0]          cmd_pd;
   logic [NUM_SRC-1:0]        rsp_valid;
   logic [NUM_SRC-1:0]        rsp_ready;
   logic [NUM_SRC*BEAT_W-1:0] rsp_pd;
   logic [NUM_SRC-1:0]        cdt_pop;
   logic [SEL_W-1:0]          src_sel;
   logic                      op_load;
   logic                      dout_valid;
   logic                      dout_ready;
   logic [BEAT_W-1:0]         dout_pd;
   logic                      eg_done;
   logic [31:0]               beat_num;

   sdp_mrdma_eg_lanes #(
      .LANES  (LANES),
      .LANE_W (LANE_W),
      .DEPTH  (DEPTH),
      .NUM_SRC(NUM_SRC),
      .CNT_W  (CNT_W)
   ) dut (
      .nvdla_core_clk     (clk),
      .nvdla_core_rst     (rst),
      .cmd_pvld           (cmd_pvld),
      .cmd_prdy           (cmd_prdy),
      .cmd_pd             (cmd_pd),
      .rsp_valid          (rsp_valid),
      .rsp_ready          (rsp_ready),
      .rsp_pd             (rsp_pd),
      .rd_cdt_lat_fifo_pop(cdt_pop),
      .reg2dp_src_sel     (src_sel),
      .op_load            (op_load),
      .dout_valid         (dout_valid),
      .dout_ready         (dout_ready),
      .dout_pd            (dout_pd),
      .eg_done            (eg_done),
      .dp2reg_beat_num    (beat_num)
   );

   always #5 clk = ~clk;

   // Behavioural model state
   lane_t              lq [LANES][$];
   bit                 m_run;
   logic [LANES-1:0]   m_mask;
   int                 m_cnt;
   bit                 m_last;
   int                 m_beat;
   bit                 m_done;
   logic [NUM_SRC-1:0] m_cdt;
   logic [31:0]        m_num;
   bit                 auto_clr;
   int                 errors = 0;
   int                 checks = 0;

   task automatic chk(input string tag, input logic [639:0] act, input logic [639:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < LANES; i++) lq[i].delete();
      m_run  = 1'b0;
      m_mask = '0;
      m_cnt  = 0;
      m_last = 1'b0;
      m_beat = 0;
      m_done = 1'b0;
      m_cdt  = '0;
      m_num  = '0;
   endtask

   function automatic logic [NUM_SRC-1:0] exp_ready();
      logic [NUM_SRC-1:0] r;
      logic [LANES-1:0]   m;
      int                 s;
      r = '0;
      s = int'(src_sel);
      if (s < NUM_SRC) begin
         m    = rsp_pd[s*BEAT_W + DATA_W +: LANES];
         r[s] = 1'b1;
         for (int i = 0; i < LANES; i++)
            if (m[i] && lq[i].size() >= DEPTH) r[s] = 1'b0;
      end
      return r;
   endfunction

   function automatic bit exp_valid();
      bit v;
      v = m_run;
      for (int i = 0; i < LANES; i++)
         if (m_mask[i] && lq[i].size() == 0) v = 1'b0;
      return v;
   endfunction

   function automatic logic [BEAT_W-1:0] exp_pd();
      logic [DATA_W-1:0] d;
      d = '0;
      for (int i = 0; i < LANES; i++)
         if (m_mask[i] && lq[i].size() > 0) d[i*LANE_W +: LANE_W] = lq[i][0];
      return {m_mask, d};
   endfunction

   function automatic logic [DATA_W-1:0] rand_data();
      logic [DATA_W-1:0] d;
      for (int k = 0; k < DATA_W / 32; k++) d[k*32 +: 32] = $urandom();
      return d;
   endfunction

   task automatic set_src(input int s, input logic [LANES-1:0] m, input logic [DATA_W-1:0] d);
      rsp_pd[s*BEAT_W +: BEAT_W] = {m, d};
   endtask

   // One clock: compare outputs at the falling edge, then advance the model
   task automatic cycle();
      logic [NUM_SRC-1:0] e_rdy;
      bit                 e_vld, r_acc, d_acc, c_acc, nxt_done;
      logic [LANES-1:0]   rm, cm;
      int                 s;
      @(negedge clk);
      e_rdy = exp_ready();
      e_vld = exp_valid();
      chk("rsp_ready", rsp_ready, e_rdy);
      chk("cmd_prdy", cmd_prdy, !m_run);
      chk("dout_valid", dout_valid, e_vld);
      if (e_vld) chk("dout_pd", dout_pd, exp_pd());
      chk("eg_done", eg_done, m_done);
      chk("cdt_pop", cdt_pop, m_cdt);
      chk("beat_num", beat_num, m_num);

      s        = int'(src_sel);
      r_acc    = (s < NUM_SRC) && rsp_valid[s] && e_rdy[s];
      d_acc    = e_vld && dout_ready;
      c_acc    = !m_run && cmd_pvld;
      nxt_done = 1'b0;
      m_cdt    = '0;
      if (d_acc) begin
         for (int i = 0; i < LANES; i++) if (m_mask[i]) void'(lq[i].pop_front());
         if (m_num != 32'hFFFF_FFFF) m_num = m_num + 1;
         if (m_beat == m_cnt) begin
            m_run    = 1'b0;
            nxt_done = m_last;
         end else begin
            m_beat++;
         end
      end
      if (op_load) m_num = d_acc ? 32'd1 : 32'd0;
      if (r_acc) begin
         rm = rsp_pd[s*BEAT_W + DATA_W +: LANES];
         for (int i = 0; i < LANES; i++)
            if (rm[i]) lq[i].push_back(rsp_pd[s*BEAT_W + i*LANE_W +: LANE_W]);
         m_cdt[s] = 1'b1;
      end
      if (c_acc) begin
         cm     = cmd_pd[CNT_W +: LANES];
         m_mask = cm;
         m_cnt  = int'(cmd_pd[CNT_W-1:0]);
         m_last = cmd_pd[CNT_W+LANES];
         m_beat = 0;
         if (cm != '0) m_run = 1'b1;
         else nxt_done = cmd_pd[CNT_W+LANES];
      end
      m_done = nxt_done;
      @(posedge clk);
      #1;
      if (auto_clr) begin
         if (c_acc) cmd_pvld = 1'b0;
         if (r_acc) rsp_valid = '0;
      end
   endtask

   // Asynchronous reset; outputs are checked while reset is still held
   task automatic do_reset();
      rsp_valid  = '0;
      cmd_pvld   = 1'b0;
      op_load    = 1'b0;
      dout_ready = 1'b0;
      rst        = 1'b1;
      m_reset();
      #1;
      chk("rst_dout_valid", dout_valid, 1'b0);
      chk("rst_dout_pd", dout_pd, '0);
      chk("rst_eg_done", eg_done, 1'b0);
      chk("rst_cdt_pop", cdt_pop, '0);
      chk("rst_beat_num", beat_num, 32'd0);
      chk("rst_cmd_prdy", cmd_prdy, 1'b1);
      chk("rst_rsp_ready", rsp_ready, exp_ready());
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic send_rsp(input int s, input logic [LANES-1:0] m, input int budget);
      set_src(s, m, rand_data());
      rsp_valid    = '0;
      rsp_valid[s] = 1'b1;
      for (int k = 0; k < budget && rsp_valid != '0; k++) cycle();
      chk("rsp_accept", rsp_valid, '0);
      rsp_valid = '0;
   endtask

   task automatic send_cmd(input bit last, input logic [LANES-1:0] m, input int cnt);
      cmd_pd   = {last, m, CNT_W'(cnt)};
      cmd_pvld = 1'b1;
      for (int k = 0; k < 40 && cmd_pvld; k++) cycle();
      chk("cmd_accept", cmd_pvld, 1'b0);
      cmd_pvld = 1'b0;
   endtask

   initial begin
      logic [DATA_W-1:0] d;
      int cyc;
      rst        = 1'b1;
      src_sel    = '0;
      rsp_pd     = '0;
      cmd_pd     = '0;
      auto_clr   = 1'b1;
      do_reset();

      // Single beat, all lanes, lane0 = 0xA..A
      d = rand_data();
      d[LANE_W-1:0] = {(LANE_W/4){4'hA}};
      set_src(0, 4'b1111, d);
      rsp_valid = 3'b001;
      for (int k = 0; k < 20 && rsp_valid != '0; k++) cycle();
      chk("t1_rsp_accept", rsp_valid, '0);
      dout_ready = 1'b1;
      send_cmd(1'b1, 4'b1111, 0);
      repeat (4) cycle();
      chk("t1_beat_num", beat_num, 32'd1);

      // Partial mask: eight beats on lanes 0-1
      for (int n = 0; n < 8; n++) send_rsp(0, 4'b0011, 20);
      send_cmd(1'b0, 4'b0011, 7);
      repeat (12) cycle();
      chk("pm_beat_num", beat_num, 32'd9);

      // Full FIFO backpressure: nine responses against depth eight
      dout_ready = 1'b0;
      send_cmd(1'b1, 4'b1111, 8);
      cyc = 0;
      for (int n = 0; n < 9; n++) begin
         set_src(0, 4'b1111, rand_data());
         rsp_valid = 3'b001;
         for (int k = 0; k < 30 && rsp_valid != '0; k++) begin
            if (cyc == 14) dout_ready = 1'b1;
            cycle();
            cyc++;
         end
         chk("bp_accept", rsp_valid, '0);
      end
      dout_ready = 1'b1;
      repeat (14) cycle();
      chk("bp_beat_num", beat_num, 32'd18);

      // Source select: source 1 only, then an out-of-range select
      auto_clr = 1'b0;
      src_sel  = 2'd1;
      for (int n = 0; n < 40; n++) begin
         for (int s = 0; s < NUM_SRC; s++) set_src(s, 4'($urandom_range(0, 15)), rand_data());
         rsp_valid = 3'b111;
         cmd_pvld  = 1'b1;
         cmd_pd    = {1'b0, 4'($urandom_range(1, 15)), 13'($urandom_range(0, 2))};
         cycle();
      end
      src_sel = 2'd3;
      repeat (10) cycle();
      auto_clr = 1'b1;

      // Zero-mask command with last set
      do_reset();
      src_sel = 2'd0;
      cmd_pd  = {1'b1, 4'b0000, 13'd5};
      cmd_pvld = 1'b1;
      cycle();
      chk("zm_eg_done", eg_done, 1'b1);
      chk("zm_dout_valid", dout_valid, 1'b0);
      repeat (2) cycle();
      chk("zm_beat_num", beat_num, 32'd0);

      // Reset while running with three entries buffered
      for (int n = 0; n < 3; n++) send_rsp(0, 4'b1111, 20);
      send_cmd(1'b1, 4'b1111, 5);
      repeat (2) cycle();
      chk("mr_pre_valid", dout_valid, 1'b1);
      do_reset();
      dout_ready = 1'b1;
      send_cmd(1'b1, 4'b1111, 0);
      repeat (4) cycle();
      do_reset();

      // op_load clears the beat counter
      for (int n = 0; n < 5; n++) send_rsp(0, 4'b0001, 20);
      dout_ready = 1'b1;
      send_cmd(1'b0, 4'b0001, 4);
      repeat (8) cycle();
      chk("ol_beat_num5", beat_num, 32'd5);
      dout_ready = 1'b0;
      op_load    = 1'b1;
      cycle();
      op_load    = 1'b0;
      chk("ol_beat_num0", beat_num, 32'd0);

      // Random traffic
      auto_clr = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 63) == 0) src_sel = SEL_W'($urandom_range(0, 3));
         for (int s = 0; s < NUM_SRC; s++) set_src(s, 4'($urandom_range(0, 15)), rand_data());
         rsp_valid  = NUM_SRC'($urandom());
         cmd_pvld   = ($urandom_range(0, 3) == 0);
         cmd_pd     = {1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 13'($urandom_range(0, 4))};
         dout_ready = ($urandom_range(0, 9) < 7);
         op_load    = ($urandom_range(0, 63) == 0);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
